// File: rtl/canvas_write_queue_pkg.sv
// Shared drawing-pipeline constants: colour encoding used by the tools and the
// framebuffer clients.
package canvas_write_queue_pkg;

  localparam int COLOR_WIDTH = 4;

  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 4'd0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 4'd1;
  localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 4'd2;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 4'd3;
  localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 4'd4;

endpackage

// File: rtl/canvas_write_queue_pixel_fifo.sv
// Small synchronous FIFO for queued pixel writes; pointers carry an extra MSB
// so that full and empty can be told apart when the indices match.
module pixel_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign dout  = mem[rd_ptr[PW-1:0]];

  // A pop on the same edge frees the slot, so a full queue may still take a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and storage update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/canvas_write_queue.sv
// Filters and deduplicates a tool's per-cycle pixel stream, queues surviving
// pixels and issues one framebuffer write per granted cycle.
module canvas_write_queue
  import canvas_write_queue_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DEPTH  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [$clog2(WIDTH)-1:0]          in_x,
  input  logic [$clog2(HEIGHT)-1:0]         in_y,
  input  logic [COLOR_WIDTH-1:0]            in_color,
  input  logic                              grant,
  output logic                              wr_en,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr,
  output logic [COLOR_WIDTH-1:0]            wr_color,
  output logic                              overflow
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int DW = AW + COLOR_WIDTH;

  logic [XW-1:0]          last_x;
  logic [YW-1:0]          last_y;
  logic [COLOR_WIDTH-1:0] last_color;
  logic                   last_valid;

  logic                   in_range;
  logic                   is_dup;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [AW-1:0]          addr;
  logic [DW-1:0]          fifo_din;
  logic [DW-1:0]          fifo_dout;

  // Candidate filter: blank colour, then off-canvas (tool wrap), then repeat of last accepted.
  always_comb begin
    in_range = (32'(in_x) < WIDTH) && (32'(in_y) < HEIGHT);
    is_dup   = last_valid && (in_x == last_x) && (in_y == last_y) && (in_color == last_color);
    accept   = 1'b0;
    if (in_color == COLOR_NONE) begin
      accept = 1'b0;
    end else if (!in_range) begin
      accept = 1'b0;
    end else if (is_dup) begin
      accept = 1'b0;
    end else begin
      accept = 1'b1;
    end
    pop      = grant && !empty;
    push     = accept && (!full || pop);
    addr     = AW'(32'(in_y) * WIDTH + 32'(in_x));
    fifo_din = {addr, in_color};
  end

  pixel_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );

  // Dedupe tracks accepted pixels, including ones later lost to overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_x     <= '0;
      last_y     <= '0;
      last_color <= COLOR_NONE;
      last_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        last_x     <= in_x;
        last_y     <= in_y;
        last_color <= in_color;
        last_valid <= 1'b1;
      end
      if (accept && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Output register: head of queue moves here on a granted pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_color <= COLOR_NONE;
    end else begin
      wr_en <= pop;
      if (pop) begin
        {wr_addr, wr_color} <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_canvas_write_queue.sv
// Directed bench for canvas_write_queue on a 6x6 canvas with a 4-deep queue;
// expected writes go to a scoreboard queue and are matched as wr_en pulses.
module tb_canvas_write_queue;
  import canvas_write_queue_pkg::*;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int D  = 4;
  localparam int AW = 6;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [2:0]             in_x;
  logic [2:0]             in_y;
  logic [COLOR_WIDTH-1:0] in_color;
  logic                   grant;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [COLOR_WIDTH-1:0] wr_color;
  logic                   overflow;

  int checks   = 0;
  int failures = 0;
  int writes   = 0;
  int w0;
  logic [AW+COLOR_WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  canvas_write_queue #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_x    (in_x),
    .in_y    (in_y),
    .in_color(in_color),
    .grant   (grant),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_color(wr_color),
    .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int x, input int y, input logic [COLOR_WIDTH-1:0] c);
    in_x     = 3'(x);
    in_y     = 3'(y);
    in_color = c;
  endtask

  task automatic expect_px(input int x, input int y, input logic [COLOR_WIDTH-1:0] c);
    logic [AW-1:0] a;
    a = AW'(y * W + x);
    exp_q.push_back({a, c});
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset === 1'b0 && wr_en === 1'b1) begin
      logic [AW+COLOR_WIDTH-1:0] e;
      writes++;
      check("sb_entry_available", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[AW+COLOR_WIDTH-1:COLOR_WIDTH]));
        check("wr_color", 32'(wr_color), 32'(e[COLOR_WIDTH-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with arbitrary inputs.
    reset = 1'b1;
    grant = 1'b1;
    drive(5, 7, COLOR_RED);
    #12;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_color", 32'(wr_color), 32'(COLOR_NONE));
    check("rst_overflow", 32'(overflow), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(2);
    drive(0, 0, COLOR_NONE);
    tick(2);

    // Plus-stroke in GREEN with latency check.
    w0 = writes;
    drive(1, 1, COLOR_GREEN); expect_px(1, 1, COLOR_GREEN);
    tick(1);
    check("latency_n1_wr_en", 32'(wr_en), 32'd0);
    tick(1);
    check("latency_n2_wr_en", 32'(wr_en), 32'd1);
    drive(2, 1, COLOR_GREEN); expect_px(2, 1, COLOR_GREEN); tick(1);
    drive(2, 2, COLOR_GREEN); expect_px(2, 2, COLOR_GREEN); tick(1);
    drive(1, 2, COLOR_GREEN); expect_px(1, 2, COLOR_GREEN); tick(1);
    drive(1, 1, COLOR_GREEN); expect_px(1, 1, COLOR_GREEN); tick(1);
    tick(6);
    check("plus_writes", 32'(writes - w0), 32'd5);
    check("plus_drained", 32'(exp_q.size()), 32'd0);

    // Edge stroke: x=6 and y=6 wrap values are dropped.
    w0 = writes;
    drive(5, 5, COLOR_RED); expect_px(5, 5, COLOR_RED); tick(1);
    drive(6, 5, COLOR_RED); tick(1);
    drive(5, 6, COLOR_RED); tick(1);
    drive(4, 5, COLOR_RED); expect_px(4, 5, COLOR_RED); tick(1);
    drive(5, 4, COLOR_RED); expect_px(5, 4, COLOR_RED); tick(1);
    tick(4);
    check("edge_writes", 32'(writes - w0), 32'd3);
    check("edge_overflow", 32'(overflow), 32'd0);

    // Blank colour is never written; the same spot in BLUE is.
    w0 = writes;
    drive(2, 2, COLOR_NONE); tick(3);
    tick(2);
    check("none_writes", 32'(writes - w0), 32'd0);
    drive(2, 2, COLOR_BLUE); expect_px(2, 2, COLOR_BLUE); tick(4);
    check("blue_writes", 32'(writes - w0), 32'd1);

    // grant low: fifth pixel overflows; held (4,0) must stay deduped after drain.
    w0 = writes;
    grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(i, 0, COLOR_BLUE);
      if (i < 4) expect_px(i, 0, COLOR_BLUE);
      tick(1);
    end
    tick(2);
    check("stall_overflow", 32'(overflow), 32'd1);
    check("stall_wr_en", 32'(wr_en), 32'd0);
    check("stall_writes", 32'(writes - w0), 32'd0);
    grant = 1'b1;
    tick(8);
    check("drain_writes", 32'(writes - w0), 32'd4);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_overflow_sticky", 32'(overflow), 32'd1);

    // Clear overflow, fill the queue, then push and pop at full each cycle.
    #2;
    reset = 1'b1;
    #1;
    check("rst2_overflow", 32'(overflow), 32'd0);
    tick(1);
    reset = 1'b0;
    w0 = writes;
    grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i, 1, COLOR_RED); expect_px(i, 1, COLOR_RED); tick(1);
    end
    check("fill_wr_en", 32'(wr_en), 32'd0);
    grant = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i, 3, COLOR_RED); expect_px(i, 3, COLOR_RED); tick(1);
    end
    check("full_pushpop_overflow", 32'(overflow), 32'd0);
    drive(0, 0, COLOR_NONE);
    tick(1);
    check("pre_reset_wr_en", 32'(wr_en), 32'd1);

    // Reset mid-drain: outputs clear between edges, pending entries vanish.
    #2;
    reset = 1'b1;
    #1;
    check("middrain_wr_en", 32'(wr_en), 32'd0);
    check("middrain_wr_addr", 32'(wr_addr), 32'd0);
    check("middrain_wr_color", 32'(wr_color), 32'(COLOR_NONE));
    check("middrain_writes_before", 32'(writes - w0), 32'd5);
    exp_q.delete();
    w0 = writes;
    tick(1);
    reset = 1'b0;
    tick(8);
    check("no_stale_writes", 32'(writes - w0), 32'd0);
    check("final_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
